// File: rtl/match_checker.sv
// match_checker
//   Response checker for combinational-block harnesses. Compares a reference
//   output against a DUT output on qualified cycles. It keeps running totals
//   of samples, mismatches, the index of the first mismatch, and a sticky OR
//   of the bits that differed. An IDLE/RUN/DONE state machine frames each run.
//
//   Optional feature macro: CHECKER_TIMEOUT_EN
//     When defined, a run with no qualified sample for TIMEOUT RUN cycles is
//     forced to DONE and the timeout port is raised.
//
// Handshake: start/stop are single-cycle pulses, and start wins over stop.
//   sample_en qualifies ref_val/dut_val only in RUN, and only when start is
//   low. Every effect is visible after the next rising edge of clk.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-low reset
//   start, stop     run framing pulses
//   sample_en       qualifies ref_val/dut_val
//   ref_val/dut_val compared vectors (W bits)
//   busy/done       state RUN / state DONE
//   mismatch        last qualified sample mismatched
//   samples/errors  qualified / mismatched sample counts (saturating)
//   first_err_idx   0-based sample index of first mismatch
//   first_err_valid first_err_idx is meaningful
//   err_bits        sticky OR of ref_val^dut_val over mismatches
//   timeout         run ended by timeout (CHECKER_TIMEOUT_EN only)
//   state_dbg       raw state register for checkers
module match_checker #(
  parameter int W       = 1,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             sample_en,
  input  logic [W-1:0]     ref_val,
  input  logic [W-1:0]     dut_val,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] samples,
  output logic [CNT_W-1:0] errors,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_valid,
  output logic [W-1:0]     err_bits,
`ifdef CHECKER_TIMEOUT_EN
  output logic             timeout,
`endif
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t       state_q, state_d;
  logic         qual;
  logic [W-1:0] diff;
  logic         mis;
  logic         sat_hit;
  logic         to_hit;

  // A sample on a start cycle belongs to no run and is discarded.
  assign qual = (state_q == S_RUN) && sample_en && !start;
  assign diff = ref_val ^ dut_val;
  assign mis  = |diff;
  // The sample that brings samples to all-ones is the last one of the run.
  assign sat_hit = qual && (samples == CNT_MAX - CNT_W'(1));

`ifdef CHECKER_TIMEOUT_EN
  logic [CNT_W-1:0] idle_cnt;

  assign to_hit = (state_q == S_RUN) && !start && !stop && !qual &&
                  (idle_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else if (start) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else if (state_q == S_RUN) begin
      if (qual) idle_cnt <= '0;
      else if (idle_cnt != CNT_MAX) idle_cnt <= idle_cnt + CNT_W'(1);
      if (to_hit) timeout <= 1'b1;
    end
  end
`else
  // Without the timeout option a run ends only by stop, start or saturation.
  // The comparison keeps the shared TIMEOUT parameter referenced; it is
  // constant false for any legal TIMEOUT.
  assign to_hit = (TIMEOUT < 0);
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start has priority over stop everywhere.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (start)                          state_d = S_RUN;
        else if (stop || sat_hit || to_hit) state_d = S_DONE;
      end
      S_DONE: if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    state_dbg = state_q;
  end

  // Run statistics. Start always clears, since it always (re)enters RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samples         <= '0;
      errors          <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
      err_bits        <= '0;
      mismatch        <= 1'b0;
    end else if (start) begin
      samples         <= '0;
      errors          <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
      err_bits        <= '0;
      mismatch        <= 1'b0;
    end else if (qual) begin
      if (samples != CNT_MAX) samples <= samples + CNT_W'(1);
      mismatch <= mis;
      if (mis) begin
        if (errors != CNT_MAX) errors <= errors + CNT_W'(1);
        err_bits <= err_bits | diff;
        if (!first_err_valid) begin
          first_err_idx   <= samples;
          first_err_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_match_checker.sv
// Bench for match_checker. Instance A: W=3, CNT_W=16, TIMEOUT=10.
// Instance B: W=1, CNT_W=4, which exercises saturation.
module tb_match_checker;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A signals
  logic        start_a = 0, stop_a = 0, sen_a = 0;
  logic [2:0]  ref_a = 0, dut_a = 0;
  logic        busy_a, done_a, mis_a, fev_a;
  logic [15:0] samples_a, errors_a, first_a;
  logic [2:0]  bits_a;
  logic [1:0]  st_a;
  // Instance B signals
  logic        start_b = 0, stop_b = 0, sen_b = 0;
  logic        ref_b = 0, dut_b = 0;
  logic        busy_b, done_b, mis_b, fev_b;
  logic [3:0]  samples_b, errors_b, first_b;
  logic        bits_b;
  logic [1:0]  st_b;
`ifdef CHECKER_TIMEOUT_EN
  logic        timeout_a, timeout_b;
`endif

  match_checker #(.W(3), .CNT_W(16), .TIMEOUT(10)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .stop(stop_a),
    .sample_en(sen_a), .ref_val(ref_a), .dut_val(dut_a),
    .busy(busy_a), .done(done_a), .mismatch(mis_a), .samples(samples_a),
    .errors(errors_a), .first_err_idx(first_a), .first_err_valid(fev_a),
    .err_bits(bits_a),
`ifdef CHECKER_TIMEOUT_EN
    .timeout(timeout_a),
`endif
    .state_dbg(st_a)
  );

  match_checker #(.W(1), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .stop(stop_b),
    .sample_en(sen_b), .ref_val(ref_b), .dut_val(dut_b),
    .busy(busy_b), .done(done_b), .mismatch(mis_b), .samples(samples_b),
    .errors(errors_b), .first_err_idx(first_b), .first_err_valid(fev_b),
    .err_bits(bits_b),
`ifdef CHECKER_TIMEOUT_EN
    .timeout(timeout_b),
`endif
    .state_dbg(st_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each run is a log of per-sample diffs. Every output is derived
  // from that log (count, mismatch count, first nonzero index, OR of diffs).
  logic [2:0] log_mem [2][0:255];
  int         log_n   [2];
  int         m_state [2];   // 0 idle, 1 run, 2 done
  int         quiet   [2];   // RUN cycles since entry or last sample
  bit         m_to    [2];
  int         cnt_max [2] = '{65535, 15};

  task automatic model_clear(int k);
    m_state[k] = 0; log_n[k] = 0; quiet[k] = 0; m_to[k] = 0;
  endtask

  task automatic model_edge(int k, bit st, bit sp, bit se, logic [2:0] r, logic [2:0] d);
    if (st) begin
      m_state[k] = 1; log_n[k] = 0; quiet[k] = 0; m_to[k] = 0;
    end else if (m_state[k] == 1) begin
      if (se) begin
        log_mem[k][log_n[k]] = r ^ d;
        log_n[k]++;
        quiet[k] = 0;
      end else begin
        quiet[k]++;
      end
      if (sp || log_n[k] == cnt_max[k]) m_state[k] = 2;
`ifdef CHECKER_TIMEOUT_EN
      else if (k == 0 && quiet[k] == 10) begin
        m_state[k] = 2; m_to[k] = 1;
      end
`endif
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_clear(0);
      model_clear(1);
    end else begin
      model_edge(0, start_a, stop_a, sen_a, ref_a, dut_a);
      model_edge(1, start_b, stop_b, sen_b, {2'b00, ref_b}, {2'b00, dut_b});
    end
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    int e_err, e_first;
    bit e_fev, e_mis;
    logic [2:0] e_bits;
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        e_err = 0; e_first = 0; e_fev = 0; e_mis = 0; e_bits = 3'b000;
        for (int i = 0; i < log_n[k]; i++) begin
          if (log_mem[k][i] != 3'b000) begin
            if (!e_fev) begin
              e_first = i;
              e_fev = 1;
            end
            e_err++;
            e_bits = e_bits | log_mem[k][i];
          end
        end
        if (log_n[k] > 0) e_mis = (log_mem[k][log_n[k]-1] != 3'b000);
        if (k == 0) begin
          check("a_busy", 32'(busy_a), 32'(m_state[0] == 1));
          check("a_done", 32'(done_a), 32'(m_state[0] == 2));
          check("a_samples", 32'(samples_a), 32'(log_n[0]));
          check("a_errors", 32'(errors_a), 32'(e_err));
          check("a_first_idx", 32'(first_a), 32'(e_first));
          check("a_first_valid", 32'(fev_a), 32'(e_fev));
          check("a_err_bits", 32'(bits_a), 32'(e_bits));
          check("a_mismatch", 32'(mis_a), 32'(e_mis));
`ifdef CHECKER_TIMEOUT_EN
          check("a_timeout", 32'(timeout_a), 32'(m_to[0]));
`endif
        end else begin
          check("b_busy", 32'(busy_b), 32'(m_state[1] == 1));
          check("b_done", 32'(done_b), 32'(m_state[1] == 2));
          check("b_samples", 32'(samples_b), 32'(log_n[1]));
          check("b_errors", 32'(errors_b), 32'(e_err));
          check("b_first_idx", 32'(first_b), 32'(e_first));
          check("b_first_valid", 32'(fev_b), 32'(e_fev));
          check("b_err_bits", 32'(bits_b), 32'(e_bits[0]));
          check("b_mismatch", 32'(mis_b), 32'(e_mis));
        end
      end
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic step_a(bit st, bit sp, bit se, logic [2:0] r, logic [2:0] d);
    @(posedge clk); #1;
    start_a = st; stop_a = sp; sen_a = se; ref_a = r; dut_a = d;
  endtask

  task automatic idle_a();
    step_a(0, 0, 0, 3'd0, 3'd0);
  endtask

  task automatic step_b(bit st, bit sp, bit se, logic r, logic d);
    @(posedge clk); #1;
    start_b = st; stop_b = sp; sen_b = se; ref_b = r; dut_b = d;
  endtask

  task automatic check_a_zero(string tag);
    check({tag, "_busy"}, 32'(busy_a), 0);
    check({tag, "_done"}, 32'(done_a), 0);
    check({tag, "_samples"}, 32'(samples_a), 0);
    check({tag, "_errors"}, 32'(errors_a), 0);
    check({tag, "_first_valid"}, 32'(fev_a), 0);
    check({tag, "_err_bits"}, 32'(bits_a), 0);
    check({tag, "_mismatch"}, 32'(mis_a), 0);
  endtask

  initial begin
    // Clock/reset
    reset = 1'b1;
    #1 reset = 1'b0;
    chk_on = 1;
    repeat (3) @(posedge clk);
    #1;
    check_a_zero("rst");
    check("rst_b_samples", 32'(samples_b), 0);
    reset = 1'b1;

    // IDLE ignores stop and samples
    step_a(0, 1, 1, 3'd1, 3'd6);
    idle_a();
    check_a_zero("idle_ign");

    // Eight matching samples, then stop
    step_a(1, 0, 0, 3'd0, 3'd0);
    for (int i = 0; i < 8; i++) step_a(0, 0, 1, 3'(i), 3'(i));
    step_a(0, 1, 0, 3'd0, 3'd0);
    idle_a();
    check("t1_samples", 32'(samples_a), 8);
    check("t1_errors", 32'(errors_a), 0);
    check("t1_first_valid", 32'(fev_a), 0);
    check("t1_done", 32'(done_a), 1);

    // DONE ignores samples and stop
    step_a(0, 0, 1, 3'd1, 3'd2);
    step_a(0, 1, 0, 3'd0, 3'd0);
    idle_a();
    check("done_hold_samples", 32'(samples_a), 8);
    check("done_hold_errors", 32'(errors_a), 0);

    // Mismatches at indices 3 (diff 001) and 6 (diff 100)
    step_a(1, 0, 0, 3'd0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] r;
      r = 3'(i);
      step_a(0, 0, 1, r, r ^ ((i == 3) ? 3'b001 : (i == 6) ? 3'b100 : 3'b000));
      if (i == 7) begin
        check("t2_mismatch_after6", 32'(mis_a), 1);
        check("t2_errors_after6", 32'(errors_a), 2);
      end
    end
    step_a(0, 1, 0, 3'd0, 3'd0);
    idle_a();
    check("t2_errors", 32'(errors_a), 2);
    check("t2_first_idx", 32'(first_a), 3);
    check("t2_first_valid", 32'(fev_a), 1);
    check("t2_err_bits", 32'(bits_a), 32'h5);
    check("t2_mismatch_last", 32'(mis_a), 0);
    check("t2_samples", 32'(samples_a), 8);

    // Restart: start+stop together, sample on start cycle discarded
    step_a(1, 0, 0, 3'd0, 3'd0);
    for (int i = 0; i < 5; i++) step_a(0, 0, 1, 3'd2, 3'd2);
    step_a(1, 1, 1, 3'd1, 3'd0);
    idle_a();
    check("t4_busy", 32'(busy_a), 1);
    check("t4_samples", 32'(samples_a), 0);
    check("t4_errors", 32'(errors_a), 0);
    for (int i = 0; i < 2; i++) step_a(0, 0, 1, 3'd7, 3'd7);
    step_a(0, 1, 0, 3'd0, 3'd0);
    idle_a();
    check("t4_samples2", 32'(samples_a), 2);
    check("t4_done", 32'(done_a), 1);

    // Asynchronous reset mid-run with errors=4
    step_a(1, 0, 0, 3'd0, 3'd0);
    for (int i = 0; i < 4; i++) step_a(0, 0, 1, 3'd0, 3'd3);
    step_a(0, 0, 1, 3'd5, 3'd5);
    idle_a();
    check("t6_errors_pre", 32'(errors_a), 4);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check_a_zero("t6_async");
    check("t6_state", 32'(st_a), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle_a();
    check_a_zero("t6_after");

    // Instance B saturation: CNT_W=4, 20 matching samples
    step_b(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step_b(0, 0, 1, 1'(i), 1'(i));
    step_b(0, 0, 0, 0, 0);
    check("t5_samples", 32'(samples_b), 15);
    check("t5_done", 32'(done_b), 1);
    check("t5_busy", 32'(busy_b), 0);
    check("t5_errors", 32'(errors_b), 0);

`ifdef CHECKER_TIMEOUT_EN
    // Timeout after 10 quiet RUN cycles
    step_a(1, 0, 0, 3'd0, 3'd0);
    for (int i = 0; i < 9; i++) idle_a();
    check("to_busy_before", 32'(busy_a), 1);
    idle_a();
    check("to_done", 32'(done_a), 1);
    check("to_flag", 32'(timeout_a), 1);
    step_a(1, 0, 0, 3'd0, 3'd0);
    idle_a();
    check("to_cleared", 32'(timeout_a), 0);
`endif

    idle_a();
    idle_a();
    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
